// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port indices, route mode,
// header field offsets and the dimension-ordered route function.
package noc_pkg;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_EAST  = 3'd2;
  localparam logic [2:0] PORT_SOUTH = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  typedef enum logic {
    ROUTE_XY = 1'b0,
    ROUTE_YX = 1'b1
  } route_mode_e;

  // Header bit at the offset carries the field MSB.
  function automatic int hdr_x_off();
    return 1;
  endfunction

  function automatic int hdr_y_off(input int cs);
    return 1 + cs;
  endfunction

  function automatic logic [2:0] route_port(
    input logic [7:0]  rx,
    input logic [7:0]  ry,
    input logic [7:0]  dx,
    input logic [7:0]  dy,
    input route_mode_e mode
  );
    logic [2:0] px;
    logic [2:0] py;
    px = PORT_LOCAL;
    py = PORT_LOCAL;
    if (dx > rx)      px = PORT_EAST;
    else if (dx < rx) px = PORT_WEST;
    if (dy < ry)      py = PORT_NORTH;
    else if (dy > ry) py = PORT_SOUTH;
    if (mode == ROUTE_XY)
      return (px != PORT_LOCAL) ? px : py;
    return (py != PORT_LOCAL) ? py : px;
  endfunction

endpackage

// File: rtl/xy_route_stage_if.sv
// Arbiter-side and output-side bundle of the XY route stage.
// slave is the stage itself, master is whoever drives it.
interface xy_route_stage_if #(
  parameter int PL    = 16,
  parameter int REN   = 5,
  parameter int REN_B = 3
);

  logic [PL-1:0]    in_data;
  logic [REN_B-1:0] in_src;
  logic             in_valid;
  logic             in_ready;
  logic [REN-1:0]   ack;
  logic [PL-1:0]    out_data;
  logic [REN-1:0]   out_valid;
  logic [REN-1:0]   out_ready;
  logic [7:0]       drop_cnt;

  modport master (
    output in_data, in_src, in_valid, out_ready,
    input  in_ready, ack, out_data, out_valid, drop_cnt
  );

  modport slave (
    input  in_data, in_src, in_valid, out_ready,
    output in_ready, ack, out_data, out_valid, drop_cnt
  );

endinterface

// File: rtl/route_fifo.sv
// Occupancy-counted FIFO holding {port, packet} entries.
// Pointers wrap modulo DEPTH, so any DEPTH >= 1 works.
module route_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q];

  // Next pointers and occupancy.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = nxt(wr_q);
    if (do_pop)  rd_d = nxt(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/xy_route_stage.sv
// Buffered dimension-ordered route stage: classify at enqueue,
// queue {port, packet}, present the head on one output port.
import noc_pkg::*;

module xy_route_stage #(
  parameter int CS     = 2,
  parameter int PL     = 16,
  parameter int REN    = 5,
  parameter int REN_B  = 3,
  parameter int DEPTH  = 2,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 4,
  parameter int MODE   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CS-1:0]       router_X,
  input  logic [CS-1:0]       router_Y,
  xy_route_stage_if.slave     bus
);

  localparam int EW    = REN_B + PL;
  localparam int X_OFF = hdr_x_off();
  localparam int Y_OFF = hdr_y_off(CS);
  localparam route_mode_e RMODE =
    (MODE == 1) ? ROUTE_YX : ROUTE_XY;

  logic [CS-1:0]    dst_x, dst_y;
  logic             legal, accept, push, pop;
  logic             full, empty;
  logic [REN_B-1:0] rport, head_port;
  logic [PL-1:0]    head_pkt;
  logic [EW-1:0]    head;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  for (genvar g = 0; g < CS; g++) begin : g_hdr
    assign dst_x[CS-1-g] = bus.in_data[X_OFF+g];
    assign dst_y[CS-1-g] = bus.in_data[Y_OFF+g];
  end

  assign legal = bus.in_data[0]
              && (32'(dst_x) < MESH_X)
              && (32'(dst_y) < MESH_Y);

  assign rport = REN_B'(route_port(8'(router_X), 8'(router_Y),
                                   8'(dst_x), 8'(dst_y), RMODE));

  assign bus.in_ready = ~full;
  assign accept       = bus.in_valid & ~full;
  assign push         = accept & legal;

  route_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({rport, bus.in_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_port = head[EW-1 -: REN_B];
  assign head_pkt  = head[PL-1:0];

  // One-hot ack back to the supplying input port.
  always_comb begin
    bus.ack = '0;
    for (int p = 0; p < REN; p++)
      bus.ack[p] = accept && (bus.in_src == REN_B'(p));
  end

  // Head is shown only on its routed port.
  always_comb begin
    bus.out_valid = '0;
    for (int p = 0; p < REN; p++)
      bus.out_valid[p] = ~empty && (head_port == REN_B'(p));
  end

  assign bus.out_data = empty ? '0 : head_pkt;
  assign pop          = |(bus.out_valid & bus.out_ready);

  // Saturating count of acked-but-discarded packets.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !legal && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;

endmodule
